// File: rtl/evaluar_pareja.sv
// rtl/evaluar_pareja.sv - memory-card pair evaluation: scan, compare, hold, write back
module evaluar_pareja #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] arr_cards_in  [0:15],
  output logic [4:0] arr_cards_out [0:15],
  output logic       done,
  output logic       match,
  output logic       error,
  output logic       all_matched
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, COMPARE, HOLD, WRITE, DONE} state_t;
  typedef enum logic [1:0] {MODE_MATCH, MODE_MISMATCH, MODE_ERROR} mode_t;

  state_t        state_q, state_d;
  mode_t         mode_q, mode_d;
  logic [4:0]    arr_q [0:15];
  logic [4:0]    arr_d [0:15];
  logic [3:0]    idx_q, idx_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [3:0]    idx_a_q, idx_a_d;
  logic [3:0]    idx_b_q, idx_b_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          match_q, match_d;
  logic          error_q, error_d;
  logic          all_matched_q, all_matched_d;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    arr_d         = arr_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    idx_a_d       = idx_a_q;
    idx_b_d       = idx_b_q;
    hold_d        = hold_q;
    match_d       = match_q;
    error_d       = error_q;
    all_matched_d = all_matched_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = LOAD;
          match_d       = 1'b0;
          error_d       = 1'b0;
          all_matched_d = 1'b0;
        end
      end
      LOAD: begin
        arr_d   = arr_cards_in;
        idx_d   = 4'd0;
        cnt_d   = 2'd0;
        idx_a_d = 4'd0;
        idx_b_d = 4'd0;
        hold_d  = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (arr_q[idx_q][4:3] == 2'b01) begin
          if (cnt_q == 2'd0) idx_a_d = idx_q;
          if (cnt_q == 2'd1) idx_b_d = idx_q;
          if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
        end
        if (idx_q == 4'd15) state_d = COMPARE;
        else                idx_d   = idx_q + 4'd1;
      end
      COMPARE: begin
        if (cnt_q != 2'd2) begin
          mode_d  = MODE_ERROR;
          state_d = WRITE;
        end else if (arr_q[idx_a_q][2:0] == arr_q[idx_b_q][2:0]) begin
          mode_d  = MODE_MATCH;
          state_d = WRITE;
        end else begin
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          mode_d  = MODE_MISMATCH;
          state_d = WRITE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      WRITE: begin
        // Only face-up cards are ever touched; other states pass through.
        for (int i = 0; i < 16; i++) begin
          if (arr_q[i][4:3] == 2'b01) begin
            if (mode_q == MODE_ERROR) begin
              arr_d[i][4:3] = 2'b00;
            end else if (4'(i) == idx_a_q || 4'(i) == idx_b_q) begin
              arr_d[i][4:3] = (mode_q == MODE_MATCH) ? 2'b10 : 2'b00;
            end
          end
        end
        all_matched_d = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (arr_d[i][4:3] != 2'b10) all_matched_d = 1'b0;
        end
        match_d = (mode_q == MODE_MATCH);
        error_d = (mode_q == MODE_ERROR);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_q        <= MODE_MATCH;
      for (int i = 0; i < 16; i++) arr_q[i] <= 5'b00000;
      idx_q         <= 4'd0;
      cnt_q         <= 2'd0;
      idx_a_q       <= 4'd0;
      idx_b_q       <= 4'd0;
      hold_q        <= '0;
      match_q       <= 1'b0;
      error_q       <= 1'b0;
      all_matched_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      arr_q         <= arr_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      idx_a_q       <= idx_a_d;
      idx_b_q       <= idx_b_d;
      hold_q        <= hold_d;
      match_q       <= match_d;
      error_q       <= error_d;
      all_matched_q <= all_matched_d;
    end
  end

  assign arr_cards_out = arr_q;
  assign done          = (state_q == DONE);
  assign match         = match_q;
  assign error         = error_q;
  assign all_matched   = all_matched_q;

endmodule

// File: tb/tb_evaluar_pareja.sv
// tb/tb_evaluar_pareja.sv - bench for evaluar_pareja: vector table, random model check, corner sequences
module tb_evaluar_pareja;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] arr_cards_in  [0:15];
  logic [4:0] arr_cards_out [0:15];
  logic       done, match, error, all_matched;

  logic [79:0] in_flat;
  logic [79:0] out_flat;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      arr_cards_in[i]     = in_flat[5*i +: 5];
      out_flat[5*i +: 5]  = arr_cards_out[i];
    end
  end

  evaluar_pareja #(.HOLD_CYCLES(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .arr_cards_in (arr_cards_in),
    .arr_cards_out(arr_cards_out),
    .done         (done),
    .match        (match),
    .error        (error),
    .all_matched  (all_matched)
  );

  typedef struct {
    logic [79:0] cards;
    logic [79:0] exp_cards;
    bit          m, e, am;
    int          lat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else             pass_cnt++;
  endtask

  function automatic logic [79:0] setc(input logic [79:0] a, input int i, input logic [4:0] v);
    logic [79:0] r;
    r = a;
    r[5*i +: 5] = v;
    return r;
  endfunction

  // Reference: find all face-up cards, then decide by count and symbols.
  function automatic void model(input logic [79:0] c, output logic [79:0] o,
                                output bit m, output bit e, output bit am, output int lat);
    int up[$];
    o = c; m = 0; e = 0; lat = 19;
    for (int i = 0; i < 16; i++) if (c[5*i+3 +: 2] == 2'b01) up.push_back(i);
    if (up.size() != 2) begin
      e = 1;
      foreach (up[j]) o[5*up[j]+3 +: 2] = 2'b00;
    end else if (c[5*up[0] +: 3] == c[5*up[1] +: 3]) begin
      m = 1;
      o[5*up[0]+3 +: 2] = 2'b10;
      o[5*up[1]+3 +: 2] = 2'b10;
    end else begin
      lat = 19 + HOLD;
      o[5*up[0]+3 +: 2] = 2'b00;
      o[5*up[1]+3 +: 2] = 2'b00;
    end
    am = 1;
    for (int i = 0; i < 16; i++) if (o[5*i+3 +: 2] != 2'b10) am = 0;
  endfunction

  task automatic run(input string nm, input logic [79:0] cards, input logic [79:0] exp_cards,
                     input bit em, input bit ee, input bit eam, input int elat,
                     input logic [79:0] swap_cards, input int swap_at, input int restart_at);
    int n, dones, first;
    in_flat = cards;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " flags_clear"}, {77'd0, match, error, all_matched}, 80'd0);
    n = 0; dones = 0; first = -1;
    while (n < elat + 20) begin
      if (n == swap_at) in_flat = swap_cards;
      start = (n == restart_at);
      @(posedge clk); #1;
      n++;
      if (n == elat - 1) chk({nm, " pre_write_arr"}, out_flat, cards);
      if (done) begin
        dones++;
        if (first < 0) begin
          first = n;
          chk({nm, " arr"}, out_flat, exp_cards);
          chk({nm, " flags"}, {77'd0, match, error, all_matched}, {77'd0, em, ee, eam});
        end
      end
    end
    start = 1'b0;
    chk({nm, " latency"}, 80'(first), 80'(elat));
    chk({nm, " done_pulses"}, 80'(dones), 80'd1);
    chk({nm, " arr_hold"}, out_flat, exp_cards);
  endtask

  initial begin
    logic [79:0] c, o, fp;
    bit m, e, am;
    int lat, dones;

    // Test-plan vectors with hand-derived expectations.
    c = setc(setc(80'd0, 3, 5'b01101), 12, 5'b01101);
    tbl[0] = '{c, setc(setc(80'd0, 3, 5'b10101), 12, 5'b10101), 1, 0, 0, 19};
    c = setc(setc(80'd0, 0, 5'b01010), 15, 5'b01110);
    tbl[1] = '{c, setc(setc(80'd0, 0, 5'b00010), 15, 5'b00110), 0, 0, 0, 19 + HOLD};
    c = setc(80'd0, 7, 5'b01001);
    tbl[2] = '{c, setc(80'd0, 7, 5'b00001), 0, 1, 0, 19};
    c = setc(setc(setc(80'd0, 1, 5'b01000), 5, 5'b01111), 10, 5'b01011);
    tbl[3] = '{c, setc(setc(setc(80'd0, 1, 5'b00000), 5, 5'b00111), 10, 5'b00011), 0, 1, 0, 19};
    fp = 80'd0;
    for (int i = 0; i < 16; i++) fp = setc(fp, i, {2'b10, 3'(i)});
    tbl[4] = '{setc(setc(fp, 4, 5'b01011), 9, 5'b01011), setc(setc(fp, 4, 5'b10011), 9, 5'b10011), 1, 0, 1, 19};
    c = setc(setc(80'd0, 2, 5'b10110), 6, 5'b11001);
    tbl[5] = '{c, c, 0, 1, 0, 19};

    rst = 1'b1; start = 1'b0; in_flat = 80'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset arr", out_flat, 80'd0);
    chk("reset outs", {76'd0, done, match, error, all_matched}, 80'd0);
    rst = 1'b0;

    for (int t = 0; t < 6; t++)
      run($sformatf("vec%0d", t), tbl[t].cards, tbl[t].exp_cards, tbl[t].m, tbl[t].e,
          tbl[t].am, tbl[t].lat, 80'd0, -1, -1);

    // start re-pulsed in the middle of HOLD must not restart or queue.
    run("restart_in_hold", tbl[1].cards, tbl[1].exp_cards, 0, 0, 0, 19 + HOLD, 80'd0, -1, 20);

    // Input array scrambled during SCAN; result follows the LOAD snapshot.
    run("swap_in_scan", tbl[0].cards, tbl[0].exp_cards, 1, 0, 0, 19, {80{1'b1}}, 3, -1);

    // Reset during HOLD drops the pending update.
    in_flat = tbl[1].cards;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold arr", out_flat, 80'd0);
    chk("rst_hold outs", {76'd0, done, match, error, all_matched}, 80'd0);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    chk("rst_hold no_done", 80'(dones), 80'd0);
    run("after_rst", tbl[2].cards, tbl[2].exp_cards, 0, 1, 0, 19, 80'd0, -1, -1);

    // Random arrays against the reference model.
    for (int r = 0; r < 150; r++) begin
      int n_up, p0, p1, p;
      bit all10;
      all10 = ($urandom_range(0, 3) == 0);
      c = 80'd0;
      for (int i = 0; i < 16; i++) begin
        int s;
        s = all10 ? 1 : $urandom_range(0, 2);
        c = setc(c, i, {(s == 0) ? 2'b00 : (s == 1) ? 2'b10 : 2'b11, 3'($urandom_range(0, 7))});
      end
      n_up = $urandom_range(0, 3);
      p0 = $urandom_range(0, 15);
      p1 = $urandom_range(0, 15);
      for (int j = 0; j < n_up; j++) begin
        p = (j == 0) ? p0 : (j == 1) ? p1 : $urandom_range(0, 15);
        c[5*p+3 +: 2] = 2'b01;
      end
      if (n_up == 2 && $urandom_range(0, 1) == 1) c[5*p1 +: 3] = c[5*p0 +: 3];
      model(c, o, m, e, am, lat);
      run($sformatf("rnd%0d", r), c, o, m, e, am, lat, 80'd0, -1, -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/evaluar_pareja.md
# evaluar_pareja

Pair-evaluation block for the memory-card game: the counterpart of the random-reveal path. Once two cards are face-up, it compares them and either marks both matched or, after a visible hold time, turns them face-down again. It sits between the game-control FSM and the card array register, reading the same 16 × 5-bit array the reveal path writes.

## Interface

Card encoding, used by all card-array blocks:
- bits [4:3] hold the card state: 00 hidden, 01 face-up, 10 matched, 11 reserved.
- bits [2:0] hold the symbol, 0..7, with two cards per symbol.

Parameters:
- HOLD_CYCLES, default 50_000_000: mismatch display time in clk cycles (1 s at 50 MHz). Must be ≥1.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request one evaluation; sampled only in IDLE.
- arr_cards_in  in  5 × [0:15]  current card array.
- arr_cards_out  out  5 × [0:15]  registered updated array.
- done  out  1  one-cycle completion pulse.
- match  out  1  the two face-up cards had equal symbols.
- error  out  1  face-up count was not exactly 2.
- all_matched  out  1  after the update, all 16 cards are in state 10.

## Operation

- FSM states: IDLE, LOAD, SCAN, COMPARE, HOLD, WRITE, DONE.
- IDLE:
  - start=1 → LOAD.
  - match, error and all_matched clear on leaving IDLE.
- LOAD:
  - Copies arr_cards_in into an internal array that drives arr_cards_out directly.
  - Clears idx, cnt, idx_a and idx_b.
  - Changes to arr_cards_in after LOAD are ignored.
- SCAN:
  - Checks one card per cycle, idx 0..15.
  - A card in state 01 stores idx in idx_a if cnt=0, or in idx_b if cnt=1.
  - cnt increments per face-up card and saturates at 3.
  - idx=15 → COMPARE.
- COMPARE, one cycle:
  - cnt≠2 → WRITE in error mode.
  - cnt=2 and symbols equal → WRITE in match mode.
  - cnt=2 and symbols differ → HOLD.
- HOLD:
  - A counter runs HOLD_CYCLES cycles, then → WRITE in mismatch mode.
  - arr_cards_out keeps showing both cards face-up.
- WRITE, one cycle:
  - Match mode: cards idx_a and idx_b are set to state 10; symbols unchanged.
  - Mismatch mode: cards idx_a and idx_b are set to state 00.
  - Error mode: every card in state 01 is set to 00.
  - In all modes, cards in states 00, 10 and 11 pass through unchanged.
  - Sets match, error and all_matched; all_matched is computed on the post-write array.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
  - match, error, all_matched and arr_cards_out hold until the next start is accepted.
- start while not IDLE is ignored; it is neither queued nor allowed to restart the FSM.

## Timing

- Reset values: state IDLE; arr_cards_out all 5'b00000; done=0, match=0, error=0, all_matched=0; all counters 0.
- rst=1 at any edge, including mid-SCAN or mid-HOLD, forces the reset values on that edge. Any pending update is dropped.
- Let start be sampled high at edge k:
  - LOAD at k; SCAN runs over edges k+2..k+17; COMPARE at k+18.
  - Match or error path: WRITE at k+19; done is first sampled high at edge k+20.
  - Mismatch path: HOLD over edges k+19..k+18+HOLD_CYCLES; WRITE at k+19+HOLD_CYCLES; done sampled high at k+20+HOLD_CYCLES.
- arr_cards_out changes only on the LOAD edge and the WRITE edge.
- match, error and all_matched are valid from the edge done rises.
- Width rules:
  - idx is 4 bits and stops at 15; it does not wrap into another pass.
  - cnt is 2 bits, saturating at 3.
  - The hold counter is $clog2(HOLD_CYCLES+1) bits.

## Test plan

Benches use HOLD_CYCLES=4. Card values are written as {state, symbol}.

- Match: card 3 = 01_101 and card 12 = 01_101, all others 00_xxx; start → done sampled at edge k+20, match=1, error=0; cards 3 and 12 become 10_101, others unchanged.
- Mismatch: card 0 = 01_010 and card 15 = 01_110 → arr_cards_out still shows both face-up through edge k+22; done at edge k+24 with match=0; cards 0 and 15 become 00_010 and 00_110.
- Error path:
  - One card face-up (card 7 = 01_001) → done at edge k+20, error=1, card 7 becomes 00_001.
  - Three cards face-up → error=1, all three become state 00.
- Final pair: 14 cards at 10_xxx plus cards 4 and 9 = 01_011 → match=1 and all_matched=1 with done.
- start pulsed again during HOLD → ignored, one done pulse only. rst asserted at HOLD cycle 2 → next edge shows arr_cards_out all 0, state IDLE, done never pulses.
- Change arr_cards_in during SCAN → result matches the array captured in LOAD.
